exp_engine: RTL and testbench
=============================

Name: exp_engine

Overview:
- Parametrised iterative e^x accelerator; next generation of the lab's fixed 16-bit Taylor-series exponential.
- Computes e^x ≈ sum over k = 0..TERMS-1 of x^k/k!, using one time-shared multiplier.
- Fixed-point widths and term count are parameters; adds busy, saturation/overflow and start-while-busy rules.
- Sits behind the accelerator wrappers as a start/done compute core.

Parameters:
FRAC_W, 16, fraction bits of x and of result (x is unsigned Q0.FRAC_W)
INT_W, 2, integer bits of result
TERMS, 8, number of series terms including k=0 (range 2..16)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
start  in  1  request; sampled only in IDLE
x  in  FRAC_W  operand, unsigned fraction in [0,1)
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse when the result is valid
ovf  out  1  result saturated; valid with done, held until the next accepted start
intpart  out  INT_W  integer part of result
fracpart  out  FRAC_W  fraction part of result

Behaviour:
- One clock; reset is asynchronous and active-high; clock port clk, reset port rst.
- Reset: state=IDLE; busy=0, done=0, ovf=0, intpart=0, fracpart=0.
- Registers:
  - X (FRAC_W bits).
  - T, term, unsigned Q1.FRAC_W.
  - P, product, Q1.FRAC_W.
  - R, accumulator, INT_W+FRAC_W+1 bits, one guard bit.
  - k, counter of width clog2(TERMS)+1.
- RECIP[k] = floor(2^FRAC_W / k), FRAC_W+1 bits; RECIP[1] = 2^FRAC_W.
- FSM:
  - IDLE: start=1 -> latch X=x, T=1.0, R=1.0, k=1, go MULX.
  - MULX: P = (T*X) >> FRAC_W, truncate; go MULR.
  - MULR: T = (P*RECIP[k]) >> FRAC_W, truncate; R = R + new T; k++; if k == TERMS-1 go FIN, else MULX.
  - FIN: if R >= 2^(INT_W+FRAC_W), output all-ones and ovf=1; else output {intpart,fracpart} = R and ovf=0. done=1 for this cycle; go IDLE.
- Latency: start accepted at edge 0; done high during cycle 2*(TERMS-1)+1.
- busy: 1 in MULX/MULR/FIN, 0 in IDLE.
- Outputs hold their last value until the next FIN; they are not cleared on start.
- start while busy: ignored, never queued. start held high in IDLE on the done-following cycle begins a new run.
- x changes after acceptance have no effect.
- One multiplier of (FRAC_W+1)x(FRAC_W+1) bits, muxed between X and RECIP[k].
- rst asserted mid-run: immediate abort to reset values; no done pulse.

Optional Feature:
- Macro EXP_NEG_EN.
- Defined:
  - Adds input port neg (1 bit), latched at start.
  - When neg=1, odd-k terms are subtracted from R, computing e^-x.
  - R is clamped at 0 if a subtraction would underflow.
  - ovf can never be set.
- Undefined: no neg port; always computes e^+x; area and timing identical to the base design.

Decomposition:
- Package exp_pkg holds:
  - state enum: IDLE, MULX, MULR, FIN.
  - function recip(k, frac_w) used to build the constant table.
  - localparams for accumulator width and counter width.
- Sub-module exp_recip_rom(k -> RECIP[k]), a combinational generate-built table.
- FSM and datapath stay in exp_engine.

Test Plan:
- Defaults, x=0x0000, start pulse -> done at cycle 15, {intpart,fracpart}=0x10000, ovf=0, busy high cycles 1..15.
- x=0x8000 -> result bit-exact to the bench truncation model, ≈0x1A613 within 8 LSB; x=0xFFFF -> ≈0x2B7DF, ovf=0.
- INT_W=1, x=0xFFFF -> intpart=1, fracpart=0xFFFF, ovf=1; next run x=0 -> ovf cleared, result 0x10000.
- start re-pulsed at cycles 3 and 9 with different x -> ignored; single done with the first x's result. start held high continuously -> back-to-back runs, one done per 16 cycles.
- rst asserted at cycle 6 of a run -> all outputs 0 next cycle, no done. Fresh start afterwards -> correct result.
- With EXP_NEG_EN, neg=1, x=0x8000 -> ≈0x09B46 (e^-0.5) bit-exact to the model. x=0 -> 0x10000.

Source files
------------

// File: rtl/exp_pkg.sv
// rtl/exp_pkg.sv - shared state type, width helpers and reciprocal constant function for exp_engine
package exp_pkg;

    typedef enum logic [1:0] {IDLE, MULX, MULR, FIN} state_t;

    localparam int FRAC_W_DEF = 16;
    localparam int INT_W_DEF  = 2;
    localparam int TERMS_DEF  = 8;

    function automatic int acc_width(input int int_w, input int frac_w);
        return int_w + frac_w + 1;
    endfunction

    function automatic int cnt_width(input int terms);
        return $clog2(terms) + 1;
    endfunction

    localparam int ACC_W = acc_width(INT_W_DEF, FRAC_W_DEF);
    localparam int CNT_W = cnt_width(TERMS_DEF);

    // floor(2^frac_w / k); k=0 is never used by the series and returns 0
    function automatic int unsigned recip(input int unsigned k, input int unsigned frac_w);
        if (k == 0) begin
            return 0;
        end
        return (32'd1 << frac_w) / k;
    endfunction

endpackage

// File: rtl/exp_if.sv
// rtl/exp_if.sv - start/done request interface of exp_engine; EXP_NEG_EN adds the neg request bit
interface exp_if #(
    parameter int FRAC_W = 16,
    parameter int INT_W  = 2
);
    logic              start;
    logic [FRAC_W-1:0] x;
`ifdef EXP_NEG_EN
    logic              neg;
`endif
    logic              busy;
    logic              done;
    logic              ovf;
    logic [INT_W-1:0]  intpart;
    logic [FRAC_W-1:0] fracpart;

    modport master (
`ifdef EXP_NEG_EN
        output neg,
`endif
        output start, x,
        input  busy, done, ovf, intpart, fracpart
    );

    modport slave (
`ifdef EXP_NEG_EN
        input  neg,
`endif
        input  start, x,
        output busy, done, ovf, intpart, fracpart
    );
endinterface

// File: rtl/exp_recip_rom.sv
// rtl/exp_recip_rom.sv - combinational table of floor(2^FRAC_W / k) indexed by the series counter
module exp_recip_rom
    import exp_pkg::*;
#(
    parameter int FRAC_W = 16,
    parameter int K_W    = 4
) (
    input  logic [K_W-1:0]  k,
    output logic [FRAC_W:0] recip_k
);

    logic [FRAC_W:0] rom [2**K_W];

    // Entries past TERMS-1 are filled too so any counter value indexes a defined constant
    for (genvar i = 0; i < 2**K_W; i++) begin : g_rom
        localparam int unsigned RV = exp_pkg::recip(i, FRAC_W);
        assign rom[i] = RV[FRAC_W:0];
    end

    assign recip_k = rom[k];

endmodule

// File: rtl/exp_engine.sv
// rtl/exp_engine.sv - iterative Taylor-series e^x core with one shared multiplier
// Optional macro EXP_NEG_EN: adds bus.neg, subtracting odd terms to compute e^-x (clamped at 0).
module exp_engine
    import exp_pkg::*;
#(
    parameter int FRAC_W = FRAC_W_DEF,
    parameter int INT_W  = INT_W_DEF,
    parameter int TERMS  = TERMS_DEF
) (
    input logic  clk,
    input logic  rst,
    exp_if.slave bus
);

    localparam int AW = acc_width(INT_W, FRAC_W);
    localparam int KW = cnt_width(TERMS);

    state_t            state_q, state_d;
    logic [FRAC_W-1:0] x_q, x_d;
    logic [FRAC_W:0]   t_q, t_d;
    logic [FRAC_W:0]   p_q, p_d;
    logic [AW-1:0]     r_q, r_d;
    logic [KW-1:0]     k_q, k_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              ovf_q, ovf_d;
    logic [INT_W-1:0]  intpart_q, intpart_d;
    logic [FRAC_W-1:0] fracpart_q, fracpart_d;
`ifdef EXP_NEG_EN
    logic              neg_q, neg_d;
`endif

    logic [FRAC_W:0]     recip_k;
    logic [FRAC_W:0]     mul_a, mul_b, mul_q;
    logic [2*FRAC_W+1:0] mul_p;
    logic [FRAC_W-1:0]   mul_lo_unused;
    logic                mul_hi_unused;
    logic [AW-1:0]       term_ext, r_sum;

    exp_recip_rom #(.FRAC_W(FRAC_W), .K_W(KW)) u_recip_rom (
        .k       (k_q),
        .recip_k (recip_k)
    );

    // MULX scales the term by x, MULR divides it by k; both keep bits [2F:F]
    assign mul_a = (state_q == MULX) ? t_q : p_q;
    assign mul_b = (state_q == MULX) ? {1'b0, x_q} : recip_k;
    assign mul_p = mul_a * mul_b;
    assign {mul_hi_unused, mul_q, mul_lo_unused} = mul_p;
    assign term_ext = AW'(mul_q);

    always_comb begin
        r_sum = r_q + term_ext;
`ifdef EXP_NEG_EN
        if (neg_q && k_q[0]) begin
            r_sum = (r_q >= term_ext) ? (r_q - term_ext) : '0;
        end
`endif
    end

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        t_d        = t_q;
        p_d        = p_q;
        r_d        = r_q;
        k_d        = k_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        ovf_d      = ovf_q;
        intpart_d  = intpart_q;
        fracpart_d = fracpart_q;
`ifdef EXP_NEG_EN
        neg_d      = neg_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    x_d         = bus.x;
                    t_d         = '0;
                    t_d[FRAC_W] = 1'b1;
                    r_d         = '0;
                    r_d[FRAC_W] = 1'b1;
                    k_d         = KW'(1);
                    busy_d      = 1'b1;
                    state_d     = MULX;
`ifdef EXP_NEG_EN
                    neg_d       = bus.neg;
`endif
                end
            end
            MULX: begin
                p_d     = mul_q;
                state_d = MULR;
            end
            MULR: begin
                t_d = mul_q;
                r_d = r_sum;
                k_d = k_q + KW'(1);
                if (k_q == KW'(TERMS - 1)) begin
                    // Result registers load here so they are valid alongside done in FIN
                    state_d = FIN;
                    done_d  = 1'b1;
                    if (r_sum[AW-1]) begin
                        intpart_d  = '1;
                        fracpart_d = '1;
                        ovf_d      = 1'b1;
                    end else begin
                        {intpart_d, fracpart_d} = r_sum[AW-2:0];
                        ovf_d                   = 1'b0;
                    end
                end else begin
                    state_d = MULX;
                end
            end
            FIN: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            x_q        <= '0;
            t_q        <= '0;
            p_q        <= '0;
            r_q        <= '0;
            k_q        <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            intpart_q  <= '0;
            fracpart_q <= '0;
`ifdef EXP_NEG_EN
            neg_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            t_q        <= t_d;
            p_q        <= p_d;
            r_q        <= r_d;
            k_q        <= k_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
            intpart_q  <= intpart_d;
            fracpart_q <= fracpart_d;
`ifdef EXP_NEG_EN
            neg_q      <= neg_d;
`endif
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.ovf      = ovf_q;
    assign bus.intpart  = intpart_q;
    assign bus.fracpart = fracpart_q;

endmodule

// File: tb/tb_exp_engine.sv
// tb/tb_exp_engine.sv - randomized self-checking bench for exp_engine against a series reference model
module tb_exp_engine;
    import exp_pkg::*;

    localparam int F     = FRAC_W_DEF;
    localparam int TERMS = TERMS_DEF;
    localparam int LAT   = 2 * (TERMS - 1) + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    exp_if #(.FRAC_W(F), .INT_W(2)) b0 ();
    exp_if #(.FRAC_W(F), .INT_W(1)) b1 ();

    exp_engine #(.FRAC_W(F), .INT_W(2), .TERMS(TERMS)) dut0 (.clk(clk), .rst(rst), .bus(b0));
    exp_engine #(.FRAC_W(F), .INT_W(1), .TERMS(TERMS)) dut1 (.clk(clk), .rst(rst), .bus(b1));

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint obs, input longint expv);
        n_vec++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Series e^(+/-x) = sum x^k/k!, each term rebuilt from the previous with truncating fixed point
    function automatic longint model(input longint xv, input bit nv, input int int_w, output bit ov);
        longint one = longint'(1) << F;
        longint t = one;
        longint r = one;
        longint p;
        for (int k = 1; k < TERMS; k++) begin
            p = (t * xv) >> F;
            t = (p * (one / k)) >> F;
            if (nv && (k % 2 == 1)) r = (r >= t) ? r - t : 0;
            else                    r = r + t;
        end
        if (r >= (longint'(1) << (int_w + F))) begin
            ov = 1'b1;
            return (longint'(1) << (int_w + F)) - 1;
        end
        ov = 1'b0;
        return r;
    endfunction

    task automatic drive(input int inst, input bit st, input longint xv);
        logic [F-1:0] xs;
        xs = xv[F-1:0];
        if (inst == 0) begin b0.start = st; b0.x = xs; end
        else           begin b1.start = st; b1.x = xs; end
    endtask

    function automatic logic sig_busy(input int inst);
        if (inst == 0) return b0.busy;
        return b1.busy;
    endfunction

    function automatic logic sig_done(input int inst);
        if (inst == 0) return b0.done;
        return b1.done;
    endfunction

    function automatic logic sig_ovf(input int inst);
        if (inst == 0) return b0.ovf;
        return b1.ovf;
    endfunction

    function automatic longint sig_res(input int inst);
        if (inst == 0) return longint'({b0.intpart, b0.fracpart});
        return longint'({b1.intpart, b1.fracpart});
    endfunction

    task automatic run(input int inst, input longint xv, input bit nv, input string tag,
                       output longint res_o);
        longint expr;
        bit     expo;
        int     lat;
        bit     busy_ok;
        bit     got;
        expr = model(xv, nv, (inst == 0) ? 2 : 1, expo);
        @(negedge clk);
        drive(inst, 1'b1, xv);
        lat = 0; busy_ok = 1'b1; got = 1'b0; res_o = -1;
        for (int c = 1; c <= 40 && !got; c++) begin
            @(negedge clk);
            if (c == 1) drive(inst, 1'b0, longint'($urandom));
            if (!sig_busy(inst)) busy_ok = 1'b0;
            if (sig_done(inst)) begin
                got = 1'b1; lat = c; res_o = sig_res(inst);
                check({tag, "/ovf"}, longint'(sig_ovf(inst)), longint'(expo));
            end
        end
        check({tag, "/latency"}, lat, LAT);
        check({tag, "/busy"}, busy_ok, 1);
        check({tag, "/result"}, res_o, expr);
        @(negedge clk);
        check({tag, "/idle"}, {sig_busy(inst), sig_done(inst)}, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, n_vec=%0d", n_vec);
        $fatal(1, "watchdog");
    end

    initial begin
        longint res, expr, xa;
        bit     expo;
        real    ideal, diff;
        int     cnt, first;
        int     dcyc[$];

        drive(0, 1'b0, 0);
        drive(1, 1'b0, 0);
`ifdef EXP_NEG_EN
        b0.neg = 1'b0;
        b1.neg = 1'b0;
`endif
        #1;
        check("reset/out0", {b0.busy, b0.done, b0.ovf, b0.intpart, b0.fracpart}, 0);
        check("reset/out1", {b1.busy, b1.done, b1.ovf, b1.intpart, b1.fracpart}, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        run(0, 0, 1'b0, "x0", res);
        check("x0/const", res, 'h10000);

        run(0, 'h8000, 1'b0, "x8000", res);
        ideal = $exp(real'('h8000) / 65536.0) * 65536.0;
        diff = real'(res) - ideal;
        if (diff < 0.0) diff = -diff;
        check("x8000/approx", diff <= 8.0, 1);

        run(0, 'hFFFF, 1'b0, "xffff", res);
        ideal = $exp(real'('hFFFF) / 65536.0) * 65536.0;
        diff = real'(res) - ideal;
        if (diff < 0.0) diff = -diff;
        check("xffff/approx", diff <= 16.0, 1);
        check("xffff/noovf", b0.ovf, 0);

        run(1, 'hFFFF, 1'b0, "int1_sat", res);
        check("int1_sat/const", res, 'h1FFFF);
        check("int1_sat/ovf", b1.ovf, 1);
        run(1, 0, 1'b0, "int1_clr", res);
        check("int1_clr/const", res, 'h10000);
        check("int1_clr/ovf", b1.ovf, 0);

        // start re-pulsed with other operands while busy must be ignored
        xa = longint'($urandom_range(0, 65535));
        expr = model(xa, 1'b0, 2, expo);
        @(negedge clk);
        drive(0, 1'b1, xa);
        cnt = 0; first = 0; res = -1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (b0.done) begin cnt++; first = c; res = sig_res(0); end
            drive(0, (c == 3 || c == 9), longint'($urandom));
        end
        check("repulse/count", cnt, 1);
        check("repulse/cycle", first, LAT);
        check("repulse/result", res, expr);

        // start held high: back-to-back runs
        xa = longint'($urandom_range(0, 65535));
        expr = model(xa, 1'b0, 2, expo);
        @(negedge clk);
        drive(0, 1'b1, xa);
        dcyc.delete();
        for (int c = 1; c <= 48; c++) begin
            @(negedge clk);
            if (b0.done) begin
                dcyc.push_back(c);
                check("held/result", sig_res(0), expr);
            end
        end
        drive(0, 1'b0, 0);
        check("held/count", dcyc.size(), 3);
        for (int i = 0; i < dcyc.size(); i++) check("held/cycle", dcyc[i], LAT + 16 * i);
        repeat (20) @(negedge clk);

        // reset mid-run aborts without a done pulse
        xa = longint'($urandom_range(1, 65535));
        @(negedge clk);
        drive(0, 1'b1, xa);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 1) drive(0, 1'b0, xa);
        end
        rst = 1'b1;
        @(negedge clk);
        check("rst/out", {b0.busy, b0.done, b0.ovf, b0.intpart, b0.fracpart}, 0);
        rst = 1'b0;
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (b0.done || b0.busy) cnt++;
        end
        check("rst/quiet", cnt, 0);
        run(0, xa, 1'b0, "rst/fresh", res);

        for (int i = 0; i < 20; i++) run(0, longint'($urandom_range(0, 65535)), 1'b0, "rand0", res);
        for (int i = 0; i < 8; i++)  run(1, longint'($urandom_range(0, 65535)), 1'b0, "rand1", res);

`ifdef EXP_NEG_EN
        b0.neg = 1'b1;
        run(0, 'h8000, 1'b1, "neg8000", res);
        check("neg8000/const", res, 'h09B46);
        run(0, 0, 1'b1, "neg0", res);
        check("neg0/const", res, 'h10000);
        for (int i = 0; i < 8; i++) begin
            run(0, longint'($urandom_range(0, 65535)), 1'b1, "randneg", res);
            check("randneg/ovf", b0.ovf, 0);
        end
        b0.neg = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
